// File: rtl/subtractor_pkg.sv
// Shared definitions for the signed subtractor slice.
//   DEFAULT_WIDTH  default operand/result width
//   MAX_WIDTH      widest supported operand width
//   signed_max()   bit pattern of 2^(w-1)-1, zero-extended to MAX_WIDTH
//   signed_min()   bit pattern of -2^(w-1) in the low w bits, upper bits zero
//   sub_result_t   {sub, ovp, ovn} combinational result bundle
package subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned MAX_WIDTH     = 64;

  // The struct is sized for the widest build; users consume the low WIDTH bits.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] sub;
    logic                 ovp;
    logic                 ovn;
  } sub_result_t;

  function automatic logic [MAX_WIDTH-1:0] signed_max(input int unsigned w);
    logic [MAX_WIDTH-1:0] v;
    v = ({{(MAX_WIDTH-1){1'b0}}, 1'b1} << (w - 1)) - 1'b1;
    return v;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] signed_min(input int unsigned w);
    logic [MAX_WIDTH-1:0] v;
    v = {{(MAX_WIDTH-1){1'b0}}, 1'b1} << (w - 1);
    return v;
  endfunction

endpackage

// File: rtl/sub_core.sv
// Combinational core of the signed subtractor: A - B with overflow flags.
// Build option: SUBTRACTOR_SAT_EN clamps the result to the signed range on
// overflow; without it the result wraps.
// Ports:
//   A    in   WIDTH  signed minuend
//   B    in   WIDTH  signed subtrahend
//   res  out  sub_result_t  {sub (low WIDTH bits valid), ovp, ovn}
module sub_core
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output sub_result_t      res
);

  logic [WIDTH:0] w_diff;
  logic           w_a_neg;
  logic           w_b_neg;
  logic           w_ovp;
  logic           w_ovn;
  logic           w_unused_diff_msb;

  // Sign-extended by one bit, so the true difference always fits.
  assign w_diff  = {A[WIDTH-1], A} - {B[WIDTH-1], B};
  assign w_a_neg = A[WIDTH-1];
  assign w_b_neg = B[WIDTH-1];

  // Overflow only possible with opposite-sign operands; the wrapped MSB then
  // disagrees with the sign of A.
  assign w_ovp = ~w_a_neg &  w_b_neg &  w_diff[WIDTH-1];
  assign w_ovn =  w_a_neg & ~w_b_neg & ~w_diff[WIDTH-1];

  // Flags are derived from the wrapped MSB; the extra bit is not needed.
  assign w_unused_diff_msb = w_diff[WIDTH];

`ifdef SUBTRACTOR_SAT_EN
  logic [MAX_WIDTH-1:0] w_max;
  logic [MAX_WIDTH-1:0] w_min;
  assign w_max = signed_max(WIDTH);
  assign w_min = signed_min(WIDTH);
`endif

  always_comb begin
    res     = '0;
    res.ovp = w_ovp;
    res.ovn = w_ovn;
    res.sub[WIDTH-1:0] = w_diff[WIDTH-1:0];
`ifdef SUBTRACTOR_SAT_EN
    if (w_ovp) begin
      res.sub[WIDTH-1:0] = w_max[WIDTH-1:0];
    end else if (w_ovn) begin
      res.sub[WIDTH-1:0] = w_min[WIDTH-1:0];
    end
`endif
  end

endmodule

// File: rtl/signed_subtractor.sv
// Registered two's-complement subtractor (sub = A - B) with positive and
// negative overflow flags and a one-cycle output register stage.
// Build option: SUBTRACTOR_SAT_EN selects saturating instead of wrapping results.
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      A/B sampled when high
//   A, B       in   WIDTH  signed operands
//   sub        out  WIDTH  registered result
//   OvP, OvN   out  1      registered positive/negative overflow flags
//   out_valid  out  1      one-cycle pulse per new result
module signed_subtractor
  import subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] sub,
  output logic             OvP,
  output logic             OvN,
  output logic             out_valid
);

  sub_result_t      w_res;
  logic [WIDTH-1:0] r_sub;
  logic             r_ovp;
  logic             r_ovn;
  logic             r_valid;

  sub_core #(.WIDTH(WIDTH)) u_core (
    .A   (A),
    .B   (B),
    .res (w_res)
  );

  // Upper struct bits are zero padding for narrower builds.
  if (WIDTH < MAX_WIDTH) begin : g_pad
    logic w_unused_pad;
    assign w_unused_pad = ^w_res.sub[MAX_WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sub   <= '0;
      r_ovp   <= 1'b0;
      r_ovn   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sub <= w_res.sub[WIDTH-1:0];
        r_ovp <= w_res.ovp;
        r_ovn <= w_res.ovn;
      end
    end
  end

  assign sub       = r_sub;
  assign OvP       = r_ovp;
  assign OvN       = r_ovn;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_signed_subtractor.sv
// Self-checking bench for signed_subtractor (WIDTH = 8). Honours
// SUBTRACTOR_SAT_EN for expected results.
module tb_signed_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] sub;
  logic         OvP;
  logic         OvN;
  logic         out_valid;

  int total;
  int bad;

  signed_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .sub       (sub),
    .OvP       (OvP),
    .OvN       (OvN),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sub_wrap;
    logic [W-1:0] sub_sat;
    logic         ovp;
    logic         ovn;
    logic         valid;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [W-1:0] es,
                           input logic ep, input logic en, input logic ev);
    chk({tag, ".sub"}, 64'(sub), 64'(es));
    chk({tag, ".OvP"}, 64'(OvP), 64'(ep));
    chk({tag, ".OvN"}, 64'(OvN), 64'(en));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: true difference in wide integer arithmetic, then classify.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] s, output logic p, output logic n);
    longint da, db, diff, mx, mn;
    logic [63:0] bits;
    da   = longint'($signed(a));
    db   = longint'($signed(b));
    diff = da - db;
    mx   = (longint'(1) <<< (W - 1)) - 1;
    mn   = -(longint'(1) <<< (W - 1));
    p    = diff > mx;
    n    = diff < mn;
    bits = diff;
`ifdef SUBTRACTOR_SAT_EN
    if (p) bits = mx;
    else if (n) bits = mn;
`endif
    s = bits[W-1:0];
  endfunction

  vec_t vecs[$];
  logic [W-1:0] e_sub;
  logic         e_ovp, e_ovn, e_valid;
  logic [W-1:0] m_sub;
  logic         m_p, m_n;

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_valid = 1'b1;
    A        = 8'h05;
    B        = 8'h03;

    // Reset held two cycles with in_valid high: nothing may come out.
    for (int i = 0; i < 2; i++) begin
      step();
      check_all($sformatf("reset%0d", i), '0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;

    //           v     a      b      wrap   sat    ovp   ovn   valid
    vecs.push_back('{1'b1, 8'h9C, 8'h28, 8'h74, 8'h80, 1'b0, 1'b1, 1'b1}); // -100-40
    vecs.push_back('{1'b1, 8'h64, 8'hD8, 8'h8C, 8'h7F, 1'b1, 1'b0, 1'b1}); // 100-(-40)
    vecs.push_back('{1'b1, 8'h64, 8'h28, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1}); // 100-40
    vecs.push_back('{1'b1, 8'h28, 8'h64, 8'hC4, 8'hC4, 1'b0, 1'b0, 1'b1}); // 40-100
    vecs.push_back('{1'b1, 8'h00, 8'h80, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b1}); // 0-(-128)
    vecs.push_back('{1'b1, 8'h80, 8'h00, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1}); // -128-0
    vecs.push_back('{1'b0, 8'h11, 8'h22, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0}); // hold
    vecs.push_back('{1'b1, 8'h7F, 8'h80, 8'hFF, 8'h7F, 1'b1, 1'b0, 1'b1}); // 127-(-128)
    vecs.push_back('{1'b1, 8'h80, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b1}); // -128-127
    vecs.push_back('{1'b0, 8'h00, 8'h01, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0}); // hold flags
    vecs.push_back('{1'b1, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1}); // -1-(-1)

    foreach (vecs[i]) begin
      in_valid = vecs[i].v;
      A        = vecs[i].a;
      B        = vecs[i].b;
      step();
`ifdef SUBTRACTOR_SAT_EN
      check_all($sformatf("vec%0d", i), vecs[i].sub_sat, vecs[i].ovp, vecs[i].ovn, vecs[i].valid);
`else
      check_all($sformatf("vec%0d", i), vecs[i].sub_wrap, vecs[i].ovp, vecs[i].ovn, vecs[i].valid);
`endif
    end

    // Mid-stream reset: a transaction concurrent with rst is discarded.
    in_valid = 1'b1; A = 8'h10; B = 8'h03;
    step();
    check_all("mid_pre", 8'h0D, 1'b0, 1'b0, 1'b1);
    rst = 1'b1; A = 8'h64; B = 8'hD8;
    step();
    check_all("mid_rst", '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; in_valid = 1'b0;
    step();
    check_all("post_idle", '0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1; A = 8'h05; B = 8'h07;
    step();
    check_all("post_first", 8'hFE, 1'b0, 1'b0, 1'b1);

    // Random stimulus against the reference, including sporadic resets.
    e_sub = 8'hFE; e_ovp = 1'b0; e_ovn = 1'b0; e_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 31) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      A        = W'($urandom);
      B        = W'($urandom);
      if ($urandom_range(0, 7) == 0) A = {1'b1, {(W-1){1'b0}}};
      if ($urandom_range(0, 7) == 0) B = {1'b1, {(W-1){1'b0}}};
      if (rst) begin
        e_sub = '0; e_ovp = 1'b0; e_ovn = 1'b0; e_valid = 1'b0;
      end else begin
        e_valid = in_valid;
        if (in_valid) begin
          model(A, B, m_sub, m_p, m_n);
          e_sub = m_sub; e_ovp = m_p; e_ovn = m_n;
        end
      end
      step();
      check_all($sformatf("rnd%0d", i), e_sub, e_ovp, e_ovn, e_valid);
      chk($sformatf("rnd%0d.excl", i), 64'(OvP & OvN), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
